// File: rtl/qsys_pio_in_edge.sv
// Avalon-MM input PIO: synchronizes and debounces an external input bus, latches
// edges in a write-1-to-clear capture register and raises a masked level interrupt.
module qsys_pio_in_edge #(
  parameter int WIDTH           = 10,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 5,
  parameter int EDGE_TYPE       = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] stable_q, stable_d;
  logic [WIDTH-1:0] capture_q, capture_d;
  logic [WIDTH-1:0] irqmask_q, irqmask_d;
  logic [31:0]      readdata_d;

  logic [WIDTH-1:0] rise, fall, edge_pulse;
  logic             wr_en, mask_wr, cap_wr;
  logic [WIDTH-1:0] clear_bits;

  // Only the low WIDTH bits of writedata are architected.
  logic unused_writedata;
  assign unused_writedata = ^writedata;

  // Two-flop synchronizer; sync_q is the first value safe to use in logic.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples
      // pre-edge values; blocking here would collapse the two stages into one.
      meta_q <= in_port;
      sync_q <= meta_q;
    end
  end

  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_bypass
      assign stable_d = sync_q;
    end else begin : g_debounce
      localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEBOUNCE_CYCLES - 1);

      logic [WIDTH-1:0][CNT_W-1:0] cnt_q, cnt_d;

      // A bit is accepted only after DEBOUNCE_CYCLES consecutive disagreeing samples;
      // any agreeing sample restarts the count, so the counter can never wrap.
      always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves
        // it unassigned, which would otherwise infer a latch.
        stable_d = stable_q;
        cnt_d    = '0;
        for (int i = 0; i < WIDTH; i++) begin
          if (sync_q[i] != stable_q[i]) begin
            if (cnt_q[i] == LAST_CNT) begin
              stable_d[i] = sync_q[i];
            end else begin
              cnt_d[i] = cnt_q[i] + 1'b1;
            end
          end
        end
      end

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_d;
        end
      end
    end
  endgenerate

  // Edges are taken on the cycle stable changes, so capture and DATA update together.
  assign rise       = stable_d & ~stable_q;
  assign fall       = ~stable_d & stable_q;
  assign edge_pulse = (EDGE_TYPE == 0) ? rise :
                      (EDGE_TYPE == 1) ? fall : (rise | fall);

  assign wr_en      = chipselect & ~write_n;
  assign mask_wr    = wr_en & (address == 2'd2);
  assign cap_wr     = wr_en & (address == 2'd3);
  assign clear_bits = {WIDTH{cap_wr}} & writedata[WIDTH-1:0];

  // Set is ORed in after the clear so a coincident edge keeps the bit.
  assign capture_d  = (capture_q & ~clear_bits) | edge_pulse;
  assign irqmask_d  = mask_wr ? writedata[WIDTH-1:0] : irqmask_q;

  always_comb begin
    readdata_d = '0;
    case (address)
      2'd0:    readdata_d[WIDTH-1:0] = stable_q;
      2'd2:    readdata_d[WIDTH-1:0] = irqmask_q;
      2'd3:    readdata_d[WIDTH-1:0] = capture_q;
      default: readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stable_q  <= '0;
      capture_q <= '0;
      irqmask_q <= '0;
      readdata  <= '0;
    end else begin
      stable_q  <= stable_d;
      capture_q <= capture_d;
      irqmask_q <= irqmask_d;
      readdata  <= readdata_d;
    end
  end

  assign irq = |(capture_q & irqmask_q);

endmodule

// File: tb/tb_qsys_pio_in_edge.sv
// Scoreboarded bench for qsys_pio_in_edge: three instances (rising/debounced,
// falling/debounced, any-edge/bypass) share one bus; reads are checked by a monitor.
module tb_qsys_pio_in_edge;

  localparam int W = 10;
  localparam int SEL_R = 0;
  localparam int SEL_F = 1;
  localparam int SEL_A = 2;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [1:0]    address;
  logic          chipselect;
  logic          write_n;
  logic [31:0]   writedata;
  logic [W-1:0]  in_port;
  logic [31:0]   rd_r, rd_f, rd_a;
  logic          irq_r, irq_f, irq_a;

  always #5 clk = ~clk;

  qsys_pio_in_edge #(.WIDTH(W), .DEBOUNCE_CYCLES(4), .CNT_W(5), .EDGE_TYPE(0)) u_rise (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rd_r), .irq(irq_r));

  qsys_pio_in_edge #(.WIDTH(W), .DEBOUNCE_CYCLES(4), .CNT_W(5), .EDGE_TYPE(1)) u_fall (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rd_f), .irq(irq_f));

  qsys_pio_in_edge #(.WIDTH(W), .DEBOUNCE_CYCLES(0), .CNT_W(5), .EDGE_TYPE(2)) u_any (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rd_a), .irq(irq_a));

  typedef struct {
    int          sel;
    logic [31:0] data;
    logic        irq;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;

  int checks   = 0;
  int failures = 0;

  logic rd_req = 1'b0;
  logic rd_valid_q = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Readdata is valid one cycle after the read request was presented.
  always @(posedge clk) rd_valid_q <= rd_req;

  always @(negedge clk) begin
    if (rd_valid_q) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_read: got a read with empty scoreboard expected none");
      end else begin
        mon_e = sb_q.pop_front();
        case (mon_e.sel)
          SEL_R: begin
            check({mon_e.name, "_data"}, rd_r, mon_e.data);
            check({mon_e.name, "_irq"}, {31'd0, irq_r}, {31'd0, mon_e.irq});
          end
          SEL_F: begin
            check({mon_e.name, "_data"}, rd_f, mon_e.data);
            check({mon_e.name, "_irq"}, {31'd0, irq_f}, {31'd0, mon_e.irq});
          end
          default: begin
            check({mon_e.name, "_data"}, rd_a, mon_e.data);
            check({mon_e.name, "_irq"}, {31'd0, irq_a}, {31'd0, mon_e.irq});
          end
        endcase
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    repeat (10) tick();
  endtask

  task automatic rd(input int sel, input logic [1:0] addr, input logic [31:0] exp_data,
                    input logic exp_irq, input string name);
    exp_t e;
    e.sel  = sel;
    e.data = exp_data;
    e.irq  = exp_irq;
    e.name = name;
    sb_q.push_back(e);
    address    = addr;
    chipselect = 1'b1;
    write_n    = 1'b1;
    rd_req     = 1'b1;
    tick();
    chipselect = 1'b0;
    rd_req     = 1'b0;
  endtask

  task automatic wr(input logic [1:0] addr, input logic [31:0] data);
    address    = addr;
    writedata  = data;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n    = 1'b0;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    in_port    = '0;
    tick();
    rd(SEL_R, 2'd0, 32'h0, 1'b0, "rst_r_data");
    rd(SEL_R, 2'd3, 32'h0, 1'b0, "rst_r_cap");
    reset_n = 1'b1;
    rd(SEL_R, 2'd2, 32'h0, 1'b0, "post_rst_mask");
    rd(SEL_A, 2'd0, 32'h0, 1'b0, "post_rst_a_data");

    // Debounced acceptance boundary: stable updates 6 cycles after the change.
    in_port = 10'h001;
    repeat (5) tick();
    rd(SEL_R, 2'd0, 32'h000, 1'b0, "t1_data_early");
    rd(SEL_R, 2'd0, 32'h001, 1'b0, "t1_data_accepted");
    settle();
    rd(SEL_R, 2'd3, 32'h001, 1'b0, "t1_r_cap");
    rd(SEL_F, 2'd3, 32'h000, 1'b0, "t1_f_cap");
    rd(SEL_A, 2'd3, 32'h001, 1'b0, "t1_a_cap");
    rd(SEL_A, 2'd0, 32'h001, 1'b0, "t1_a_data");
    wr(2'd3, 32'h3FF);
    rd(SEL_R, 2'd3, 32'h000, 1'b0, "t1_r_cleared");

    // Three-cycle glitch on bit 5: rejected by debounced parts, seen by bypass part.
    in_port = 10'h021;
    repeat (3) tick();
    in_port = 10'h001;
    settle();
    rd(SEL_R, 2'd0, 32'h001, 1'b0, "t2_r_data");
    rd(SEL_R, 2'd3, 32'h000, 1'b0, "t2_r_cap");
    rd(SEL_F, 2'd3, 32'h000, 1'b0, "t2_f_cap");
    rd(SEL_A, 2'd3, 32'h020, 1'b0, "t2_a_cap");
    wr(2'd3, 32'h3FF);

    // Interrupt masking and write-1-to-clear.
    wr(2'd2, 32'h3FF);
    in_port = 10'h201;
    settle();
    rd(SEL_R, 2'd3, 32'h200, 1'b1, "t3_r_cap_irq");
    rd(SEL_R, 2'd2, 32'h3FF, 1'b1, "t3_r_mask");
    rd(SEL_F, 2'd3, 32'h000, 1'b0, "t3_f_noirq");
    rd(SEL_A, 2'd3, 32'h200, 1'b1, "t3_a_cap_irq");
    wr(2'd3, 32'h000);
    rd(SEL_R, 2'd3, 32'h200, 1'b1, "t3_clear0_keeps");
    wr(2'd3, 32'h200);
    rd(SEL_R, 2'd3, 32'h000, 1'b0, "t3_clear_bit9");
    rd(SEL_A, 2'd3, 32'h000, 1'b0, "t3_a_clear_bit9");
    in_port = 10'h203;
    settle();
    wr(2'd2, 32'h000);
    rd(SEL_R, 2'd3, 32'h002, 1'b0, "t3_mask0_keeps_cap");
    rd(SEL_A, 2'd3, 32'h002, 1'b0, "t3_a_mask0_keeps_cap");
    wr(2'd3, 32'h3FF);

    // Edge type selection on bit 2.
    in_port = 10'h207;
    settle();
    rd(SEL_R, 2'd3, 32'h004, 1'b0, "t4_rise_r");
    rd(SEL_F, 2'd3, 32'h000, 1'b0, "t4_rise_f");
    rd(SEL_A, 2'd3, 32'h004, 1'b0, "t4_rise_a");
    wr(2'd3, 32'h3FF);
    in_port = 10'h203;
    settle();
    rd(SEL_R, 2'd3, 32'h000, 1'b0, "t4_fall_r");
    rd(SEL_F, 2'd3, 32'h004, 1'b0, "t4_fall_f");
    rd(SEL_A, 2'd3, 32'h004, 1'b0, "t4_fall_a");
    wr(2'd3, 32'h3FF);

    // Set wins over a coincident clear: the write lands on the acceptance edge.
    in_port = 10'h202;
    settle();
    wr(2'd3, 32'h3FF);
    in_port = 10'h203;
    repeat (5) tick();
    wr(2'd3, 32'h001);
    rd(SEL_R, 2'd3, 32'h001, 1'b0, "t5_set_wins");
    rd(SEL_A, 2'd3, 32'h000, 1'b0, "t5_a_cleared");

    // Writes to read-only / unused addresses, then reset in the middle of debounce.
    wr(2'd0, 32'h3FF);
    wr(2'd1, 32'h3FF);
    rd(SEL_R, 2'd0, 32'h203, 1'b0, "t6_data_unchanged");
    rd(SEL_R, 2'd1, 32'h000, 1'b0, "t6_addr1_zero");
    rd(SEL_R, 2'd2, 32'h000, 1'b0, "t6_mask_unchanged");
    rd(SEL_R, 2'd3, 32'h001, 1'b0, "t6_cap_unchanged");
    wr(2'd2, 32'h3FF);
    rd(SEL_R, 2'd3, 32'h001, 1'b1, "t6_irq_on_unmask");
    in_port = 10'h3FF;
    repeat (3) tick();
    reset_n = 1'b0;
    rd(SEL_R, 2'd0, 32'h000, 1'b0, "t6_rst_data");
    rd(SEL_R, 2'd3, 32'h000, 1'b0, "t6_rst_cap");
    rd(SEL_A, 2'd0, 32'h000, 1'b0, "t6_rst_a_data");
    reset_n = 1'b1;
    repeat (5) tick();
    rd(SEL_R, 2'd0, 32'h000, 1'b0, "t6_reacc_early");
    rd(SEL_R, 2'd0, 32'h3FF, 1'b0, "t6_reacc_data");
    rd(SEL_R, 2'd3, 32'h3FF, 1'b0, "t6_reacc_cap");
    rd(SEL_A, 2'd3, 32'h3FF, 1'b0, "t6_a_reacc_cap");
    rd(SEL_F, 2'd3, 32'h000, 1'b0, "t6_f_reacc_cap");

    repeat (3) tick();
    if (sb_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
